// File: rtl/pulse_generator_pkg.sv
// Shared constants for the periodic pulse generator.
package pulse_generator_pkg;

   // Default bit width of the period control value and the cycle counter.
   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/pulse_generator.sv
// Programmable periodic strobe: one-cycle pulse every enable_val+1 clocks,
// idle while enable_val is zero. enable_val is used live (no shadow copy),
// so a period can be stretched or cut short while it is running.
module pulse_generator
   import pulse_generator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] enable_val,
   output logic             pulse
);

   logic [WIDTH-1:0] count_reg;
   logic             enabled;
   logic             terminal;

   assign enabled  = |enable_val;
   // A ">=" rather than "==" makes lowering enable_val below the running
   // count end the period on the next edge instead of waiting for a wrap.
   assign terminal = (count_reg >= enable_val);

   // Cycle counter: cleared while disabled and at terminal count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (!enabled || terminal) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   // Pulse flop: high for the one cycle following a terminal count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pulse <= 1'b0;
      end else begin
         pulse <= enabled && terminal;
      end
   end

endmodule

// File: tb/tb_pulse_generator.sv
// Randomised and directed bench for pulse_generator with a queue-based
// scoreboard fed by a period-level reference model.
module tb_pulse_generator;
   import pulse_generator_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] enable_val = '0;
   logic         pulse;

   pulse_generator #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable_val (enable_val),
      .pulse      (pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   bit exp_q[$];
   bit last_exp = 1'b0;

   // Reference model: a period is N+1 edges long; the pulse fires on the
   // edge that completes the period. Reset or N=0 restarts the period.
   int elapsed = 0;
   int n_now;
   bit e_now;
   always @(posedge clk) begin
      cycle = cycle + 1;
      n_now = int'(enable_val);
      e_now = 1'b0;
      if (!rst || n_now == 0) begin
         elapsed = 0;
      end else begin
         elapsed = elapsed + 1;
         if (elapsed >= n_now + 1) begin
            e_now   = 1'b1;
            elapsed = 0;
         end
      end
      exp_q.push_back(e_now);
      last_exp = e_now;
   end

   // Monitor: compare the registered output shortly after every edge.
   bit e_mon;
   always @(posedge clk) begin
      #1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_empty cycle %0d observed %b", cycle, pulse);
      end else begin
         e_mon = exp_q.pop_front();
         if (pulse !== e_mon) begin
            errors = errors + 1;
            $display("FAIL pulse cycle %0d N=%0d rst=%b got %b expected %b",
                     cycle, enable_val, rst, pulse, e_mon);
         end else if (e_mon) begin
            $display("pulse cycle %0d N=%0d observed %b", cycle, enable_val, pulse);
         end
      end
   end

   task automatic run(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Drop rst between edges and confirm the output clears without a clock.
   task automatic async_reset(input string tag);
      #1 rst = 1'b0;
      #1;
      checks = checks + 1;
      if (pulse !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL async_%s got %b expected 0", tag, pulse);
      end
   endtask

   task automatic sync_restart();
      rst = 1'b0;
      run(1);
      rst = 1'b1;
   endtask

   initial begin
      // Reset hold with N = 10.
      rst = 1'b0;
      enable_val = 4'd10;
      run(3);
      rst = 1'b1;
      // Nominal period: pulses after edges 11 and 22.
      run(22);
      // Minimum and maximum N.
      enable_val = 4'd1;
      run(10);
      enable_val = 4'd15;
      run(40);
      // Disable, then re-enable with N = 3.
      enable_val = 4'd0;
      run(20);
      enable_val = 4'd3;
      run(16);
      // Lower N from 10 to 5 at count 7.
      sync_restart();
      enable_val = 4'd10;
      run(7);
      enable_val = 4'd5;
      run(20);
      // Raise N from 5 to 12 at count 3.
      sync_restart();
      enable_val = 4'd5;
      run(3);
      enable_val = 4'd12;
      run(30);
      // Asynchronous reset mid-period at count 4 with N = 6.
      sync_restart();
      enable_val = 4'd6;
      run(4);
      async_reset("n6");
      run(2);
      rst = 1'b1;
      run(20);
      // Asynchronous reset while the pulse is high.
      enable_val = 4'd1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (last_exp) break;
      end
      checks = checks + 1;
      if (!last_exp) begin
         errors = errors + 1;
         $display("FAIL high_pulse_setup got %b expected 1", last_exp);
      end
      async_reset("high");
      run(1);
      rst = 1'b1;
      run(6);
      // Random configuration changes and resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) enable_val = W'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) begin
            async_reset("rand");
            run(1);
            rst = 1'b1;
         end
         run(1);
      end
      run(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
